ycbcr_rgb: RTL and testbench

- Decode-side colour converter: turns a 384-bit block of 16 YCbCr pixels back into 16 RGB pixels.
- It is the inverse of the rgb_ycbcr stage on the encrypt path.
- It sits after the three SM4 decrypt lanes in the high-level decrypt controller.
- The controller starts it with a level `start`, waits for `all_end`, then drops `start`.

---
 rtl/ycbcr_rgb.sv | 155 +++++++++++++++
 tb/tb_ycbcr_rgb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_rgb.sv
// ycbcr_rgb: 16-pixel YCbCr -> RGB block converter.
// Two-stage pixel pipeline, one pixel per cycle, fixed latency.
module ycbcr_rgb #(
  parameter int PIXELS = 16,
  parameter int FRAC   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [24*PIXELS-1:0]  din,
  output logic                  all_end,
  output logic [24*PIXELS-1:0]  dout,
  output logic                  busy
);

  localparam int W  = 24 * PIXELS;
  localparam int IW = $clog2(PIXELS);
  localparam logic [IW-1:0] LAST = IW'(PIXELS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [W-1:0]       blk;
  logic [IW-1:0]      idx;
  logic               feed;

  logic               s1_v;
  logic [IW-1:0]      s1_idx;
  logic [7:0]         s1_y;
  logic signed [19:0] s1_pr;
  logic signed [19:0] s1_pg;
  logic signed [19:0] s1_pb;

  logic [W-1:0]       dout_q;
  logic               all_end_q;

  logic [23:0]        px_in;
  logic signed [8:0]  dcb;
  logic signed [8:0]  dcr;
  logic signed [19:0] dcb_w;
  logic signed [19:0] dcr_w;
  logic signed [19:0] yw;
  logic signed [19:0] r_sum;
  logic signed [19:0] g_sum;
  logic signed [19:0] b_sum;
  logic [23:0]        px_out;
  logic               last_wr;

  function automatic logic [7:0] clamp(
    input logic signed [19:0] v
  );
    if (v < 20'sd0)
      return 8'd0;
    else if (v > 20'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

  // pick the latched pixel addressed by idx
  always_comb begin
    px_in = '0;
    for (int i = 0; i < PIXELS; i++)
      if (idx == IW'(i))
        px_in = blk[24*i +: 24];
  end

  assign dcb   = $signed({1'b0, px_in[15:8]}) - 9'sd128;
  assign dcr   = $signed({1'b0, px_in[7:0]}) - 9'sd128;
  assign dcb_w = $signed({{11{dcb[8]}}, dcb});
  assign dcr_w = $signed({{11{dcr[8]}}, dcr});

  assign yw    = $signed({12'd0, s1_y});
  assign r_sum = yw + (s1_pr >>> FRAC);
  assign g_sum = yw - (s1_pg >>> FRAC);
  assign b_sum = yw + (s1_pb >>> FRAC);

  assign px_out  = {clamp(r_sum), clamp(g_sum),
                    clamp(b_sum)};
  assign last_wr = (state == RUN) && s1_v
                   && (s1_idx == LAST);

  // control FSM, input latch and stage 1 products
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      blk    <= '0;
      idx    <= '0;
      feed   <= 1'b0;
      s1_v   <= 1'b0;
      s1_idx <= '0;
      s1_y   <= '0;
      s1_pr  <= '0;
      s1_pg  <= '0;
      s1_pb  <= '0;
    end else begin
      s1_v <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            blk   <= din;
            idx   <= '0;
            feed  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (feed) begin
            s1_v   <= 1'b1;
            s1_idx <= idx;
            s1_y   <= px_in[23:16];
            s1_pr  <= 20'sd359 * dcr_w;
            s1_pg  <= 20'sd88 * dcb_w
                      + 20'sd183 * dcr_w;
            s1_pb  <= 20'sd454 * dcb_w;
            idx    <= idx + IW'(1);
            if (idx == LAST)
              feed <= 1'b0;
          end
          if (last_wr)
            state <= DONE;
        end
        DONE: begin
          if (!start)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stage 2: clamp, write pixel, raise completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q    <= '0;
      all_end_q <= 1'b0;
    end else begin
      if (s1_v)
        for (int i = 0; i < PIXELS; i++)
          if (s1_idx == IW'(i))
            dout_q[24*i +: 24] <= px_out;
      if (last_wr)
        all_end_q <= 1'b1;
      else if (state == DONE && !start)
        all_end_q <= 1'b0;
    end
  end

  assign dout    = dout_q;
  assign all_end = all_end_q;
  assign busy    = (state == RUN);

endmodule

// File: tb/tb_ycbcr_rgb.sv
// tb_ycbcr_rgb: directed bench for ycbcr_rgb.
// Hand-computed vectors, fixed-latency checks.
module tb_ycbcr_rgb;

  localparam int P = 16;
  localparam int W = 24 * P;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         all_end;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] grey;
  logic [W-1:0] blk_a;
  logic [W-1:0] exp_a;
  logic [W-1:0] blk_b;
  logic [W-1:0] exp_b;

  ycbcr_rgb #(.PIXELS(P), .FRAC(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .din     (din),
    .all_end (all_end),
    .dout    (dout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    din   = grey;
    repeat (3) tick();
    checks++;
    if (all_end !== 1'b0) begin
      errors++;
      $display("FAIL reset_all_end: got %0b want 0",
               all_end);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
    checks++;
    if (dout !== '0) begin
      errors++;
      $display("FAIL reset_dout: got %h want 0", dout);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_edge busy: got %0b want 1",
               busy);
    end
    repeat (17) tick();
    checks++;
    if (all_end !== 1'b1 || dout !== grey) begin
      errors++;
      $display("FAIL reset_block: all_end %0b dout %h want 1 %h",
               all_end, dout, grey);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_grey();
    din   = grey;
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || all_end !== 1'b0) begin
      errors++;
      $display("FAIL grey_e0: busy %0b all_end %0b want 1 0",
               busy, all_end);
    end
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || all_end !== 1'b0) begin
        errors++;
        $display("FAIL grey_e%0d: busy %0b all_end %0b want 1 0",
                 e, busy, all_end);
      end
    end
    tick();
    checks++;
    if (all_end !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL grey_e17: all_end %0b busy %0b want 1 0",
               all_end, busy);
    end
    checks++;
    if (dout !== grey) begin
      errors++;
      $display("FAIL grey_dout: got %h want %h", dout, grey);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    din   = blk_a;
    start = 1'b1;
    repeat (18) tick();
    checks++;
    if (all_end !== 1'b1) begin
      errors++;
      $display("FAIL clamp_all_end: got %0b want 1", all_end);
    end
    for (int i = 0; i < P; i++) begin
      checks++;
      if (dout[24*i +: 24] !== exp_a[24*i +: 24]) begin
        errors++;
        $display("FAIL clamp_px%0d: got %h want %h",
                 i, dout[24*i +: 24], exp_a[24*i +: 24]);
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    din   = blk_a;
    start = 1'b1;
    repeat (18) tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (all_end !== 1'b1 || dout !== exp_a) begin
        errors++;
        $display("FAIL hold_c%0d: all_end %0b dout %h want 1 %h",
                 c, all_end, dout, exp_a);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if (all_end !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_drop: all_end %0b busy %0b want 0 0",
               all_end, busy);
    end
    checks++;
    if (dout !== exp_a) begin
      errors++;
      $display("FAIL hold_keep: got %h want %h", dout, exp_a);
    end
    din   = blk_b;
    start = 1'b1;
    repeat (17) tick();
    checks++;
    if (all_end !== 1'b0) begin
      errors++;
      $display("FAIL hold_e16: all_end %0b want 0", all_end);
    end
    tick();
    checks++;
    if (all_end !== 1'b1 || dout !== exp_b) begin
      errors++;
      $display("FAIL hold_new: all_end %0b dout %h want 1 %h",
               all_end, dout, exp_b);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_early_release();
    din   = blk_a;
    start = 1'b1;
    tick();
    repeat (3) tick();
    din = grey;
    tick();
    start = 1'b0;
    repeat (12) tick();
    checks++;
    if (all_end !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_e16: all_end %0b busy %0b want 0 1",
               all_end, busy);
    end
    tick();
    checks++;
    if (all_end !== 1'b1 || dout !== exp_a) begin
      errors++;
      $display("FAIL early_e17: all_end %0b dout %h want 1 %h",
               all_end, dout, exp_a);
    end
    tick();
    checks++;
    if (all_end !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_e18: all_end %0b busy %0b want 0 0",
               all_end, busy);
    end
    tick();
    checks++;
    if (all_end !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_idle: all_end %0b busy %0b want 0 0",
               all_end, busy);
    end
  endtask

  task automatic test_reset_mid();
    din   = blk_b;
    start = 1'b1;
    tick();
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (dout !== '0 || all_end !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: dout %h all_end %0b busy %0b want 0",
               dout, all_end, busy);
    end
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (all_end !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet_c%0d: all_end %0b busy %0b want 0",
                 c, all_end, busy);
      end
    end
    din   = blk_a;
    start = 1'b1;
    repeat (17) tick();
    checks++;
    if (all_end !== 1'b0) begin
      errors++;
      $display("FAIL mid_fresh_e16: all_end %0b want 0", all_end);
    end
    tick();
    checks++;
    if (all_end !== 1'b1 || dout !== exp_a) begin
      errors++;
      $display("FAIL mid_fresh: all_end %0b dout %h want 1 %h",
               all_end, dout, exp_a);
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    grey  = {P{24'h808080}};
    blk_a = grey;
    exp_a = grey;
    blk_a[24*0 +: 24] = 24'h0080FF;
    exp_a[24*0 +: 24] = 24'hB20000;
    blk_a[24*1 +: 24] = 24'hFFFF80;
    exp_a[24*1 +: 24] = 24'hFFD4FF;
    blk_a[24*2 +: 24] = 24'h640000;
    exp_a[24*2 +: 24] = 24'h00EC00;
    blk_a[24*3 +: 24] = 24'h8080C8;
    exp_a[24*3 +: 24] = 24'hE44D80;
    blk_a[24*4 +: 24] = 24'h803C80;
    exp_a[24*4 +: 24] = 24'h809807;
    blk_a[24*5 +: 24] = 24'h32C85A;
    exp_a[24*5 +: 24] = 24'h0035B1;
    blk_b = {P{24'h3264C8}};
    exp_b = {P{24'h960900}};

    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;

    test_reset();
    test_grey();
    test_clamp();
    test_hold();
    test_early_release();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
